// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit
// Brief    : Single-issue execution unit. Accepts one ALU operation when idle,
//            presents the result for exactly one write-back cycle and keeps
//            zero/carry flags of the last written result. The optional
//            shift-add multiplier is built only when EXEC_UNIT_MUL_EN is
//            defined; otherwise op 111 is a two-cycle NOP.
// Revision : 1.0 - initial release
// ============================================================================
module exec_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] dest,
    output logic       busy,
    output logic       wb_enable,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       flag_zero,
    output logic       flag_carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef EXEC_UNIT_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, WB = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic        accept;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic        alu_write;

    logic        wb_en_q;
    logic [1:0]  wb_addr_q;
    logic [7:0]  wb_data_q;
    logic        zero_q;
    logic        carry_q;

`ifdef EXEC_UNIT_MUL_EN
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;
    logic [1:0]  dest_q;

    // One partial product per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
`endif

    // A request is taken only while idle; start during busy has no effect.
    assign accept = (state_q == IDLE) && start;

    // Single-cycle ALU evaluated on the live operands at the accepting edge,
    // so later operand changes cannot disturb the in-flight result.
    always_comb begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        alu_write = 1'b1;
        case (op)
            OP_ADD:  {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL:  begin
                alu_res   = {a[6:0], 1'b0};
                alu_carry = a[7];
            end
            OP_MUL:  alu_write = 1'b0;  // multiplier path (or NOP) writes instead
            default: alu_write = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ALU ops take one WB cycle, MUL runs 8 cycles first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef EXEC_UNIT_MUL_EN
                    state_d = (op == OP_MUL) ? MUL_RUN : WB;
`else
                    state_d = WB;
`endif
                end
            end
`ifdef EXEC_UNIT_MUL_EN
            MUL_RUN: begin
                if (cnt_q == 3'd7) begin
                    state_d = WB;
                end
            end
`endif
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result/flag registers load only on the edge entering WB; the strobe
    // self-clears so it is high for exactly the WB cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= 2'd0;
            wb_data_q <= 8'h00;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
            acc_q     <= 16'h0000;
            mcand_q   <= 16'h0000;
            mplier_q  <= 8'h00;
            cnt_q     <= 3'd0;
            dest_q    <= 2'd0;
`endif
        end else begin
            wb_en_q <= 1'b0;
            if (accept && alu_write) begin
                wb_en_q   <= 1'b1;
                wb_addr_q <= dest;
                wb_data_q <= alu_res;
                zero_q    <= (alu_res == 8'h00);
                carry_q   <= alu_carry;
            end
`ifdef EXEC_UNIT_MUL_EN
            if (accept && (op == OP_MUL)) begin
                acc_q    <= 16'h0000;
                mcand_q  <= {8'h00, a};
                mplier_q <= b;
                cnt_q    <= 3'd0;
                dest_q   <= dest;
            end
            if (state_q == MUL_RUN) begin
                acc_q    <= acc_d;
                mcand_q  <= {mcand_q[14:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[7:1]};
                cnt_q    <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= dest_q;
                    wb_data_q <= acc_d[7:0];
                    zero_q    <= (acc_d[7:0] == 8'h00);
                    carry_q   <= |acc_d[15:8];
                end
            end
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign wb_enable  = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_unit
// Brief    : Self-checking bench for exec_unit. Expected write-backs come from
//            an independent reference model and are queued when an operation
//            is issued; a monitor pops and compares on every write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dest;
    logic       busy;
    logic       wb_enable;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       flag_zero;
    logic       flag_carry;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    exp_t sb[$];
    logic last_z = 1'b0;
    logic last_c = 1'b0;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .dest       (dest),
        .busy       (busy),
        .wb_enable  (wb_enable),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    // Reference model of one operation.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x,
                                   input logic [7:0] y, input logic [1:0] d);
        exp_t        e;
        logic [8:0]  s;
        logic [15:0] p;
        s      = 9'd0;
        p      = 16'd0;
        e.addr = d;
        e.data = 8'h00;
        e.c    = 1'b0;
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; e.data = s[7:0]; e.c = s[8]; end
            3'd1: begin e.data = x - y; e.c = (x < y); end
            3'd2: e.data = x & y;
            3'd3: e.data = x | y;
            3'd4: e.data = x ^ y;
            3'd5: e.data = ~x;
            3'd6: begin e.data = {x[6:0], 1'b0}; e.c = x[7]; end
            default: begin
                p      = {8'h00, x} * {8'h00, y};
                e.data = p[7:0];
                e.c    = |p[15:8];
            end
        endcase
        e.z = (e.data == 8'h00);
        return e;
    endfunction

    function automatic bit writes(input logic [2:0] o);
`ifdef EXEC_UNIT_MUL_EN
        return (o <= 3'd7);
`else
        return (o != 3'd7);
`endif
    endfunction

    // Write-back monitor: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (wb_enable === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: strobe with addr=%0d data=%h, required no strobe", wb_addr, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({wb_addr, wb_data, flag_zero, flag_carry} !== e) begin
                    bad++;
                    $display("FAIL wb_result: got addr=%0d data=%h z=%b c=%b, required addr=%0d data=%h z=%b c=%b",
                             wb_addr, wb_data, flag_zero, flag_carry, e.addr, e.data, e.z, e.c);
                end
            end
        end
    end

    // Issue one op from idle; returns at #1 after the accepting edge with
    // operands scrambled to prove they are no longer needed.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] d);
        exp_t e;
        e = model(o, x, y, d);
        if (writes(o)) begin
            sb.push_back(e);
            last_z = e.z;
            last_c = e.c;
        end
        op = o; a = x; b = y; dest = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        dest  = 2'($urandom);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL accept: busy=%b after start, required 1 (op=%0d)", busy, o);
        end
    endtask

    // Count edges until busy drops; optionally pulse start while busy.
    task automatic wait_done(input bit poke, output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (poke) begin
                start = n[0];
                op    = 3'($urandom);
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, wb_enable, wb_addr, wb_data, flag_zero, flag_carry} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b en=%b addr=%0d data=%h z=%b c=%b, required all 0",
                     busy, wb_enable, wb_addr, wb_data, flag_zero, flag_carry);
        end
    endtask

    task automatic test_add();
        int n;
        issue(3'd0, 8'hF0, 8'h20, 2'd2);
        total++;
        if ({wb_enable, wb_addr, wb_data, flag_zero, flag_carry} !== {1'b1, 2'd2, 8'h10, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_F0_20: en=%b addr=%0d data=%h z=%b c=%b, required en=1 addr=2 data=10 z=0 c=1",
                     wb_enable, wb_addr, wb_data, flag_zero, flag_carry);
        end
        wait_done(1'b0, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL add_occupancy: busy cycles=%0d, required 1", n);
        end
        issue(3'd0, 8'h7F, 8'h01, 2'd0);
        wait_done(1'b0, n);
        @(posedge clk); #1;
        total++;
        if ({wb_enable, wb_addr, wb_data} !== {1'b0, 2'd0, 8'h80}) begin
            bad++;
            $display("FAIL wb_hold: en=%b addr=%0d data=%h, required en=0 addr=0 data=80",
                     wb_enable, wb_addr, wb_data);
        end
    endtask

    task automatic test_sub();
        int n;
        issue(3'd1, 8'h05, 8'h05, 2'd1);
        total++;
        if ({wb_data, flag_zero, flag_carry} !== {8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_equal: data=%h z=%b c=%b, required data=00 z=1 c=0", wb_data, flag_zero, flag_carry);
        end
        wait_done(1'b0, n);
        issue(3'd1, 8'h03, 8'h04, 2'd1);
        total++;
        if ({wb_data, flag_zero, flag_carry} !== {8'hFF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sub_borrow: data=%h z=%b c=%b, required data=FF z=0 c=1", wb_data, flag_zero, flag_carry);
        end
        wait_done(1'b0, n);
    endtask

    task automatic test_logic();
        int n;
        for (int i = 0; i < 8; i++) begin
            issue(3'(2 + (i % 4)), 8'($urandom), 8'($urandom), 2'(i));
            wait_done(1'b0, n);
        end
    endtask

    task automatic test_shl_not();
        int n;
        issue(3'd6, 8'h81, 8'h00, 2'd3);
        total++;
        if ({wb_data, flag_carry} !== {8'h02, 1'b1}) begin
            bad++;
            $display("FAIL shl_81: data=%h c=%b, required data=02 c=1", wb_data, flag_carry);
        end
        wait_done(1'b0, n);
        issue(3'd5, 8'hFF, 8'h00, 2'd0);
        total++;
        if ({wb_data, flag_zero, flag_carry} !== {8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL not_FF: data=%h z=%b c=%b, required data=00 z=1 c=0", wb_data, flag_zero, flag_carry);
        end
        wait_done(1'b0, n);
    endtask

    task automatic test_mul();
        int n;
`ifdef EXEC_UNIT_MUL_EN
        issue(3'd7, 8'h12, 8'h10, 2'd3);
        wait_done(1'b1, n);
        total++;
        if (n !== 9) begin
            bad++;
            $display("FAIL mul_latency: busy cycles=%0d, required 9", n);
        end
        total++;
        if ({wb_addr, wb_data, flag_carry} !== {2'd3, 8'h20, 1'b1}) begin
            bad++;
            $display("FAIL mul_12_10: addr=%0d data=%h c=%b, required addr=3 data=20 c=1", wb_addr, wb_data, flag_carry);
        end
        issue(3'd7, 8'hFF, 8'hFF, 2'd1);
        wait_done(1'b0, n);
`else
        logic z0, c0;
        z0 = flag_zero;
        c0 = flag_carry;
        issue(3'd7, 8'h02, 8'h03, 2'd2);
        total++;
        if (wb_enable !== 1'b0) begin
            bad++;
            $display("FAIL mul_nop_strobe: en=%b, required 0", wb_enable);
        end
        wait_done(1'b0, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL mul_nop_occupancy: busy cycles=%0d, required 1", n);
        end
        total++;
        if ({flag_zero, flag_carry} !== {z0, c0}) begin
            bad++;
            $display("FAIL mul_nop_flags: z=%b c=%b, required z=%b c=%b", flag_zero, flag_carry, z0, c0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            issue(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 2'($urandom));
            // start during WB must be ignored
            start = 1'b1;
            op    = 3'($urandom_range(0, 6));
            @(posedge clk); #1;
            start = 1'b0;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b_ignore: busy=%b after start during WB, required 0", busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        int n;
`ifdef EXEC_UNIT_MUL_EN
        issue(3'd7, 8'h0F, 8'h03, 2'd1);
        repeat (3) @(posedge clk);
        #1;
`else
        issue(3'd0, 8'h33, 8'h44, 2'd3);
`endif
        reset = 1'b1;
        #1;
        if (sb.size() > 0) void'(sb.pop_back());
        last_z = 1'b0;
        last_c = 1'b0;
        total++;
        if ({busy, wb_enable, wb_addr, wb_data, flag_zero, flag_carry} !== 14'd0) begin
            bad++;
            $display("FAIL reset_abort: busy=%b en=%b addr=%0d data=%h z=%b c=%b, required all 0",
                     busy, wb_enable, wb_addr, wb_data, flag_zero, flag_carry);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // first edge after release must accept
        issue(3'd0, 8'h01, 8'h01, 2'd2);
        wait_done(1'b0, n);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 8'h00;
        b     = 8'h00;
        dest  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_add();
        test_sub();
        test_logic();
        test_shl_not();
        test_mul();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d results never written, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
REQ-004 start  input  1  request to execute one operation; sampled only when busy=0.
REQ-005 op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a by 1, 111 MUL.
REQ-006 a  input  8  first operand, from register bank read port a.
REQ-007 b  input  8  second operand, from register bank read port b; ignored for NOT/SHL.
REQ-008 dest  input  2  destination register index for the result.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 wb_enable  output  1  one-cycle write-back strobe to register bank write_enable.
REQ-011 wb_addr  output  2  write-back register index, drives register bank write_addr.
REQ-012 wb_data  output  8  write-back value, drives register bank write_data.
REQ-013 flag_zero  output  1  set when last written result was 0x00.
REQ-014 flag_carry  output  1  carry/borrow/overflow of last written result.

Function
REQ-015 FSM states SHALL be IDLE, MUL_RUN, WB; reset state IDLE.
REQ-016 In IDLE with start=1, the block SHALL latch op, a, b, dest on that edge; start with busy=1 SHALL be ignored with no side effects.
REQ-017 Ops 000-110 SHALL go IDLE->WB; the result SHALL be presented in WB, one cycle after the accepting edge.
REQ-018 MUL SHALL go IDLE->MUL_RUN for exactly 8 cycles (shift-add, one multiplier bit per cycle, 16-bit accumulator), then WB; latency 9 cycles.
REQ-019 WB SHALL last exactly one cycle with wb_enable=1, wb_addr=latched dest, wb_data=result, then return to IDLE; wb_enable=0 in all other states.
REQ-020 ADD/SUB/SHL/NOT/logic results SHALL be the low 8 bits, wrapping modulo 256; MUL result SHALL be the low 8 bits of the 16-bit product.
REQ-021 flag_carry SHALL be: ADD carry-out of bit 7; SUB 1 when a<b unsigned; SHL old a[7]; MUL 1 when product high byte nonzero; AND/OR/XOR/NOT 0.
REQ-022 flag_zero and flag_carry SHALL update only on the edge that enters WB and SHALL hold otherwise.
REQ-023 wb_addr and wb_data SHALL hold their last values outside WB.
REQ-024 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-025 Maximum throughput SHALL be one accepted operation every 2 cycles (non-MUL) or every 10 cycles (MUL).

Reset
REQ-026 On reset assertion: state=IDLE, busy=0, wb_enable=0, wb_addr=0, wb_data=0x00, flag_zero=0, flag_carry=0, multiplier accumulator/counter cleared.
REQ-027 Reset during MUL_RUN or WB SHALL abort the operation with no write-back strobe.
REQ-028 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro EXEC_UNIT_MUL_EN defined: MUL (op 111) SHALL behave per REQ-018/020/021.
REQ-030 Macro EXEC_UNIT_MUL_EN undefined: MUL_RUN state and multiplier logic SHALL be absent; op 111 SHALL pass IDLE->WB with wb_enable=0, flags unchanged (NOP, 2-cycle occupancy).

Verification
REQ-031 ADD a=0xF0 b=0x20 dest=2, start -> next cycle wb_enable=1, wb_addr=2, wb_data=0x10, flag_carry=1, flag_zero=0.
REQ-032 SUB a=0x05 b=0x05 dest=1 -> wb_data=0x00, flag_zero=1, flag_carry=0; then SUB a=0x03 b=0x04 -> wb_data=0xFF, flag_carry=1.
REQ-033 MUL (EN defined) a=0x12 b=0x10 dest=3 -> busy=1 for 9 cycles, wb_enable on cycle 9 with wb_data=0x20, flag_carry=1; start pulses during busy ignored.
REQ-034 MUL a=0x0F b=0x03, reset asserted on 4th MUL_RUN cycle -> busy=0, wb_enable never asserts, all outputs at reset values.
REQ-035 SHL a=0x81 -> wb_data=0x02, flag_carry=1; NOT a=0xFF -> wb_data=0x00, flag_zero=1, flag_carry=0.
REQ-036 EXEC_UNIT_MUL_EN undefined, op=111 a=0x02 b=0x03 -> busy for 1 cycle, wb_enable stays 0, flags unchanged.
